// File: rtl/spart_pkg.sv
// Constants and state type shared by the message transmitter and the far-end receive packer.
package spart_pkg;
  localparam int MSG_W         = 24;
  localparam int BYTE_W        = 8;
  localparam int BYTES_PER_MSG = 3;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD,
    GAP
  } tx_state_t;

  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/spart_msg_tx_if.sv
// Message-source and spart byte-port signals of the transmitter, with DUT (slave) and driver (master) views.
interface spart_msg_tx_if #(
  parameter int DEPTH = 4
);
  import spart_pkg::*;

  logic                        msg_valid;
  logic [MSG_W-1:0]            msg_data;
  logic                        msg_ready;
  logic [BYTE_W-1:0]           byte_tx;
  logic                        send_byte;
  logic                        tbr;
  logic                        msg_sent;
  logic [count_w(DEPTH)-1:0]   fifo_count;
  logic                        tx_idle;

  modport slave (
    input  msg_valid, msg_data, tbr,
    output msg_ready, byte_tx, send_byte, msg_sent, fifo_count, tx_idle
  );

  modport master (
    output msg_valid, msg_data, tbr,
    input  msg_ready, byte_tx, send_byte, msg_sent, fifo_count, tx_idle
  );
endinterface

// File: rtl/spart_msg_fifo.sv
// Small message FIFO: registered pointers/count, asynchronous read of the head entry.
module spart_msg_fifo
  import spart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [MSG_W-1:0]          i_wdata,
  input  logic                      i_pop,
  output logic [MSG_W-1:0]          o_rdata,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [MSG_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  // Head is read combinationally so the FSM can load it in the pop cycle.
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/spart_msg_tx.sv
// Queues 24-bit messages and serializes each as three bytes (low byte first) to the spart,
// with a one-cycle hold after each load and a fixed idle gap after every message.
module spart_msg_tx
  import spart_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  spart_msg_tx_if.slave        bus
);
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  tx_state_t          r_state, w_state_next;
  logic [MSG_W-1:0]   r_shreg, w_shreg_next;
  logic [1:0]         r_byte_cnt, w_byte_cnt_next;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_next;
  logic [BYTE_W-1:0]  r_byte_tx, w_byte_tx_next;
  logic               w_pop;
  logic               w_send;
  logic               w_msg_sent;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [MSG_W-1:0]   w_fifo_rdata;

  spart_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.msg_valid),
    .i_wdata (bus.msg_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (bus.fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_byte_tx  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_shreg    <= w_shreg_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_byte_tx  <= w_byte_tx_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shreg_next    = r_shreg;
    w_byte_cnt_next = r_byte_cnt;
    w_gap_cnt_next  = r_gap_cnt;
    w_byte_tx_next  = r_byte_tx;
    w_pop           = 1'b0;
    w_send          = 1'b0;
    w_msg_sent      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop           = 1'b1;
          w_shreg_next    = w_fifo_rdata;
          w_byte_cnt_next = '0;
          w_state_next    = SEND;
        end
      end
      SEND: begin
        if (bus.tbr) begin
          w_send          = 1'b1;
          w_byte_tx_next  = r_shreg[BYTE_W-1:0];
          w_shreg_next    = r_shreg >> BYTE_W;
          w_byte_cnt_next = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'(BYTES_PER_MSG - 1)) begin
            w_msg_sent     = 1'b1;
            w_gap_cnt_next = '0;
            w_state_next   = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            w_state_next = HOLD;
          end
        end
      end
      // Spart drops tbr a cycle after the load; ignore it for that cycle.
      HOLD: w_state_next = SEND;
      GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
          w_state_next = IDLE;
        end else begin
          w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The live byte is shown during the load cycle, then the latched copy holds until the next load.
  assign bus.byte_tx   = w_send ? r_shreg[BYTE_W-1:0] : r_byte_tx;
  assign bus.send_byte = w_send;
  assign bus.msg_sent  = w_msg_sent;
  assign bus.msg_ready = ~w_fifo_full;
  assign bus.tx_idle   = (r_state == IDLE) && w_fifo_empty;
endmodule
